// File: rtl/fetch_redirect_ctrl.sv
// Redirect/flush sequencer: merges WB flushes and EX branches into one held
// redirect PC for pre-IF, and marks wrong-path inst-SRAM responses for discard.
module fetch_redirect_ctrl #(
  parameter int MAX_OST = 2,
  parameter int CNT_W   = $clog2(MAX_OST + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush,
  input  logic [31:0] wb_flush_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        pf_req_fire,
  input  logic        inst_data_ok,
  output logic        flush_pipe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  redirect_cause,
  output logic        inst_resp_discard,
  output logic        ost_full
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

  localparam logic [1:0] CAUSE_BR      = 2'd0;
  localparam logic [1:0] CAUSE_EX      = 2'd1;
  localparam logic [1:0] CAUSE_ERTN    = 2'd2;
  localparam logic [1:0] CAUSE_REFETCH = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             state;
  logic [CNT_W-1:0] ost_cnt;
  logic [CNT_W-1:0] disc_cnt;
  logic [CNT_W-1:0] ost_next;
  logic [CNT_W-1:0] disc_next;
  logic             wb_evt;
  logic             br_acc;
  logic             evt;
  logic [1:0]       cause_next;
  logic [31:0]      pc_next;

  // A branch is only accepted from IDLE: any held redirect (WB or an older
  // branch) is older than the branch now in EX, so it must win.
  assign wb_evt = wb_ex | ertn_flush | wb_refetch_flush;
  assign br_acc = br_taken & ~wb_evt & (state == STATE_IDLE);
  assign evt    = wb_evt | br_acc;

  assign flush_pipe        = wb_evt;
  assign redirect_valid    = (state == STATE_HOLD);
  assign ost_full          = (ost_cnt == CNT_MAX);
  assign inst_resp_discard = inst_data_ok & ((disc_cnt != '0) | evt);

  always_comb begin
    cause_next = CAUSE_BR;
    pc_next    = br_target;
    if (wb_ex) begin
      cause_next = CAUSE_EX;
      pc_next    = wb_flush_entry;
    end else if (ertn_flush) begin
      cause_next = CAUSE_ERTN;
      pc_next    = wb_flush_entry;
    end else if (wb_refetch_flush) begin
      cause_next = CAUSE_REFETCH;
      pc_next    = wb_flush_entry;
    end
  end

  // Counters saturate rather than wrap so a protocol slip cannot alias.
  always_comb begin
    ost_next = ost_cnt;
    if (pf_req_fire && !inst_data_ok && ost_cnt != CNT_MAX)
      ost_next = ost_cnt + CNT_ONE;
    else if (!pf_req_fire && inst_data_ok && ost_cnt != '0)
      ost_next = ost_cnt - CNT_ONE;

    disc_next = disc_cnt;
    if (evt)
      disc_next = ost_next;
    else if (inst_data_ok && disc_cnt != '0)
      disc_next = disc_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= STATE_IDLE;
      redirect_pc    <= 32'd0;
      redirect_cause <= CAUSE_BR;
      ost_cnt        <= '0;
      disc_cnt       <= '0;
    end else begin
      ost_cnt  <= ost_next;
      disc_cnt <= disc_next;
      if (evt) begin
        state          <= STATE_HOLD;
        redirect_pc    <= pc_next;
        redirect_cause <= cause_next;
      end else if (state == STATE_HOLD && pf_req_fire) begin
        state <= STATE_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of redirect and discard.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex, ertn_flush, wb_refetch_flush;
  logic [31:0] wb_flush_entry;
  logic        br_taken;
  logic [31:0] br_target;
  logic        pf_req_fire, inst_data_ok;
  logic        flush_pipe, redirect_valid, inst_resp_discard, ost_full;
  logic [31:0] redirect_pc;
  logic [1:0]  redirect_cause;

  int tests  = 0;
  int failed = 0;

  // Model: pending redirect plus request/discard counts held as integers.
  bit          m_valid;
  logic [31:0] m_pc;
  int          m_cause;
  int          m_ost;
  int          m_disc;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.MAX_OST(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush),
    .wb_flush_entry    (wb_flush_entry),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .pf_req_fire       (pf_req_fire),
    .inst_data_ok      (inst_data_ok),
    .flush_pipe        (flush_pipe),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_cause    (redirect_cause),
    .inst_resp_discard (inst_resp_discard),
    .ost_full          (ost_full)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model across the rising edge.
  task automatic applyStimulus(input bit rst, input bit ex, input bit ertn, input bit rf,
                               input logic [31:0] entry, input bit br,
                               input logic [31:0] target, input bit fire, input bit ok,
                               input string tag);
    bit          wbe, ev;
    int          ost_n, disc_n;
    logic [31:0] pc_n;
    int          cause_n;
    @(negedge clk);
    resetn = ~rst; wb_ex = ex; ertn_flush = ertn; wb_refetch_flush = rf;
    wb_flush_entry = entry; br_taken = br; br_target = target;
    pf_req_fire = fire; inst_data_ok = ok;
    #1;
    wbe = ex || ertn || rf;
    ev  = wbe || (br && !m_valid);
    ost_n = m_ost + int'(fire) - int'(ok);
    if (ost_n > 2) ost_n = 2;
    if (ost_n < 0) ost_n = 0;
    checkOutput({tag, ".flush"},   32'(flush_pipe),        32'(wbe));
    checkOutput({tag, ".discard"}, 32'(inst_resp_discard), 32'(ok && (m_disc > 0 || ev)));
    checkOutput({tag, ".full"},    32'(ost_full),          32'(m_ost == 2));
    checkOutput({tag, ".valid"},   32'(redirect_valid),    32'(m_valid));
    checkOutput({tag, ".pc"},      redirect_pc,            m_pc);
    checkOutput({tag, ".cause"},   32'(redirect_cause),    32'(m_cause));
    disc_n  = ev ? ost_n : m_disc - ((ok && m_disc > 0) ? 1 : 0);
    pc_n    = wbe ? entry : target;
    cause_n = ex ? 1 : ertn ? 2 : rf ? 3 : 0;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_pc = 0; m_cause = 0; m_ost = 0; m_disc = 0;
    end else begin
      if (ev) begin
        m_valid = 1; m_pc = pc_n; m_cause = cause_n;
      end else if (m_valid && fire) begin
        m_valid = 0;
      end
      m_ost  = ost_n;
      m_disc = disc_n;
    end
  endtask

  initial begin
    bit          r_ex, r_ertn, r_rf, r_br, r_fire, r_ok, r_rst;
    logic [31:0] r_entry, r_target;

    resetn = 1'b0; wb_ex = 0; ertn_flush = 0; wb_refetch_flush = 0;
    wb_flush_entry = 0; br_taken = 0; br_target = 0; pf_req_fire = 0; inst_data_ok = 0;
    m_valid = 0; m_pc = 0; m_cause = 0; m_ost = 0; m_disc = 0;
    repeat (2) @(posedge clk);

    // T1 reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_idle");

    // T2 branch redirect, released by a fetch
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1c000100, 0, 0, "t2_br");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_hold");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "t2_fire");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "t2_drain");

    // T3 exception beats a same-cycle branch; later branch in HOLD ignored
    applyStimulus(0, 1, 0, 0, 32'h1c008000, 1, 32'h1c000200, 0, 0, "t3_ex");
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1c000999, 0, 0, "t3_br_hold");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "t3_check");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "t3_fire");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "t3_drain");

    // T4 two in flight, ertn marks both wrong-path
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "t4_fire1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "t4_fire2");
    applyStimulus(0, 0, 1, 0, 32'h1c00a000, 0, 0, 0, 0, "t4_ertn");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "t4_ok1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "t4_ok2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "t4_refire");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, "t4_ok3");

    // T5 refetch overrides a held branch in the same cycle as a fetch
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1c000300, 0, 0, "t5_br");
    applyStimulus(0, 0, 0, 1, 32'h1c000044, 0, 0, 1, 0, "t5_refetch");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "t5_hold");

    // T6 reset while holding with a pending discard
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "t6_reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_after");

    // Random traffic obeying the inst-SRAM protocol
    for (int i = 0; i < 600; i++) begin
      r_rst    = ($urandom_range(0, 99) == 0);
      r_ex     = ($urandom_range(0, 11) == 0);
      r_ertn   = ($urandom_range(0, 11) == 0);
      r_rf     = ($urandom_range(0, 11) == 0);
      r_br     = ($urandom_range(0, 3) == 0);
      r_fire   = (m_ost < 2) && ($urandom_range(0, 1) == 1);
      r_ok     = (m_ost > 0) && ($urandom_range(0, 2) != 0);
      r_entry  = $urandom;
      r_target = $urandom;
      applyStimulus(r_rst, r_ex, r_ertn, r_rf, r_entry, r_br, r_target, r_fire, r_ok, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
